// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard
// Description : Tracks in-flight register writes between ID and WB.
//               Each of the 16 architectural registers has a 2-bit count of
//               writes that have issued but not yet retired. ID stalls on a
//               source whose count is non-zero, and issue is refused while
//               the destination count is saturated at MAX_PEND.
// Ports       : clk             - single clock, rising edge
//               rst             - asynchronous, active-low reset
//               issue_valid     - an instruction leaves ID this cycle
//               issue_wb_en     - the issuing instruction writes a register
//               issue_dest      - destination register of the issue
//               issue_ready     - issue_dest count is below MAX_PEND
//               wb_valid        - WB retires a register write this cycle
//               wb_dest         - register retired by WB
//               flush           - discard every pending write
//               src_1, src_2    - ID-stage source registers
//               two_src         - src_2 is a live operand
//               hazard_detected - an ID source has a pending write
//               pending_total   - sum of all pending counts (0..48)
//               underflow_err   - sticky: WB retired a register with no
//                                 pending write
// Revision    : 1.0 - initial release
// ============================================================================
module register_scoreboard #(
    parameter int MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_wb_en,
    input  logic [3:0] issue_dest,
    output logic       issue_ready,
    input  logic       wb_valid,
    input  logic [3:0] wb_dest,
    input  logic       flush,
    input  logic [3:0] src_1,
    input  logic [3:0] src_2,
    input  logic       two_src,
    output logic       hazard_detected,
    output logic [5:0] pending_total,
    output logic       underflow_err
);

    localparam logic [1:0] c_MAX_PEND = 2'(MAX_PEND);
    localparam int         c_NUM_REGS = 16;

    logic [1:0] r_pend [c_NUM_REGS];
    logic       r_underflow_err;

    logic       w_issue_ready;
    logic       w_inc;
    logic       w_dec;
    logic       w_underflow;
    logic [5:0] w_total;

    assign w_issue_ready = (r_pend[issue_dest] != c_MAX_PEND);

    // A refused issue (saturated destination) must not touch the counter.
    assign w_inc = issue_valid & issue_wb_en & w_issue_ready;

    // Retire only decrements a non-zero counter; the zero case is an error.
    assign w_dec = wb_valid & (r_pend[wb_dest] != 2'd0);

    // A same-cycle accepted issue to the same register supplies the write
    // that WB is retiring, so that combination is not an underflow.
    assign w_underflow = wb_valid & (r_pend[wb_dest] == 2'd0)
                       & ~(w_inc & (issue_dest == wb_dest));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_pend[i] <= 2'd0;
            end
        end else if (flush) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                // Inc and dec on the same register cancel out.
                if (w_inc && (issue_dest == 4'(i)) &&
                    !(w_dec && (wb_dest == 4'(i)))) begin
                    r_pend[i] <= r_pend[i] + 2'd1;
                end else if (w_dec && (wb_dest == 4'(i)) &&
                             !(w_inc && (issue_dest == 4'(i)))) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
        end
    end

    // Sticky error flag; flush leaves it alone, only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow_err <= 1'b0;
        end else if (w_underflow) begin
            r_underflow_err <= 1'b1;
        end
    end

    always_comb begin
        w_total = 6'd0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_total = w_total + {4'd0, r_pend[i]};
        end
    end

    assign issue_ready     = w_issue_ready;
    assign hazard_detected = (r_pend[src_1] != 2'd0)
                           | (two_src & (r_pend[src_2] != 2'd0));
    assign pending_total   = w_total;
    assign underflow_err   = r_underflow_err;

endmodule

`default_nettype wire

// File: tb/tb_register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_scoreboard
// Description : Self-checking bench for register_scoreboard. Directed
//               scenarios followed by randomized traffic, all compared
//               against a count-per-register reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_scoreboard;

    localparam int MAXP = 3;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_wb_en;
    logic [3:0] issue_dest;
    logic       issue_ready;
    logic       wb_valid;
    logic [3:0] wb_dest;
    logic       flush;
    logic [3:0] src_1;
    logic [3:0] src_2;
    logic       two_src;
    logic       hazard_detected;
    logic [5:0] pending_total;
    logic       underflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding write count per register + sticky error.
    int m_pend [16];
    bit m_err;

    register_scoreboard #(.MAX_PEND(MAXP)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_wb_en     (issue_wb_en),
        .issue_dest      (issue_dest),
        .issue_ready     (issue_ready),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .flush           (flush),
        .src_1           (src_1),
        .src_2           (src_2),
        .two_src         (two_src),
        .hazard_detected (hazard_detected),
        .pending_total   (pending_total),
        .underflow_err   (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 16; i++) s += m_pend[i];
        return s;
    endfunction

    function automatic bit m_hazard();
        return (m_pend[src_1] != 0) || (two_src && m_pend[src_2] != 0);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_err = 1'b0;
    endtask

    // Called at a falling edge: apply inputs, then check outputs vs model.
    task automatic drive(input bit iv, input bit iwe, input int id,
                         input bit wv, input int wd, input bit fl,
                         input int s1, input int s2, input bit two);
        issue_valid = iv;
        issue_wb_en = iwe;
        issue_dest  = 4'(id);
        wb_valid    = wv;
        wb_dest     = 4'(wd);
        flush       = fl;
        src_1       = 4'(s1);
        src_2       = 4'(s2);
        two_src     = two;
        #1;
        check("ready",  32'(issue_ready),     32'(m_pend[issue_dest] != MAXP));
        check("hazard", 32'(hazard_detected), 32'(m_hazard()));
        check("total",  32'(pending_total),   32'(m_total()));
        check("uerr",   32'(underflow_err),   32'(m_err));
    endtask

    // Advance one clock and apply the scoreboard rules to the model.
    task automatic tick();
        bit inc, dec, und;
        int id, wd;
        @(posedge clk);
        id  = int'(issue_dest);
        wd  = int'(wb_dest);
        inc = issue_valid && issue_wb_en && (m_pend[id] < MAXP);
        dec = wb_valid && (m_pend[wd] > 0);
        und = wb_valid && (m_pend[wd] == 0) && !(inc && id == wd);
        if (flush) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
        end else begin
            if (inc) m_pend[id] = m_pend[id] + 1;
            if (dec) m_pend[wd] = m_pend[wd] - 1;
        end
        if (und) m_err = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        m_clear();
        rst = 1'b0;
        issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
        wb_valid = 0; wb_dest = 0; flush = 0;
        src_1 = 0; src_2 = 0; two_src = 0;
        #1;
        check("rst_ready",  32'(issue_ready), 1);
        check("rst_hazard", 32'(hazard_detected), 0);
        check("rst_total",  32'(pending_total), 0);
        check("rst_uerr",   32'(underflow_err), 0);
        @(negedge clk);
        rst = 1'b1;

        // Single issue, hazard, retire.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 5, 0, 5, 0, 0);
        check("r29_hz1", 32'(hazard_detected), 1);
        check("r29_tot1", 32'(pending_total), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 5, 0, 0);
        check("r29_hz0", 32'(hazard_detected), 0);
        check("r29_tot0", 32'(pending_total), 0);
        tick();

        // src_2 only counts when two_src is set.
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
        check("r30_two0", 32'(hazard_detected), 0);
        tick();
        drive(0, 0, 0, 1, 7, 0, 0, 7, 1);
        check("r30_two1", 32'(hazard_detected), 1);
        tick();

        // Saturation at MAX_PEND.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 3, 0, 0, 0, 0, 0, 0); tick();
        end
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        check("r31_ready0", 32'(issue_ready), 0);
        tick();
        drive(0, 0, 3, 1, 3, 0, 0, 0, 0);
        check("r31_tot3", 32'(pending_total), 3);
        tick();
        drive(0, 0, 3, 0, 0, 0, 0, 0, 0);
        check("r31_ready1", 32'(issue_ready), 1);
        check("r31_tot2", 32'(pending_total), 2);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();

        // Simultaneous inc and dec on the same register.
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 9, 1, 9, 0, 9, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 9, 0, 0);
        check("r32_hz", 32'(hazard_detected), 1);
        check("r32_tot", 32'(pending_total), 1);
        tick();

        // Inc and dec on different registers both apply.
        drive(1, 1, 2, 1, 9, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 2, 9, 1);
        check("r20_tot", 32'(pending_total), 1);
        tick();

        // Flush beats a simultaneous issue.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 6, 0, 0, 1, 0, 0, 0); tick();
        for (int s = 0; s < 16; s++) begin
            drive(0, 0, 0, 0, 0, 0, s, s, 1);
            check("r33_hz", 32'(hazard_detected), 0);
        end
        check("r33_tot", 32'(pending_total), 0);
        tick();

        // Inc covers a WB to an idle register: no underflow.
        drive(1, 1, 11, 1, 11, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 11, 0, 0);
        check("r21_uerr", 32'(underflow_err), 0);
        check("r21_hz", 32'(hazard_detected), 1);
        tick();

        // Underflow is sticky through flush; async reset clears it.
        drive(0, 0, 0, 1, 12, 0, 0, 0, 0); tick();
        drive(1, 1, 8, 0, 0, 1, 0, 0, 0);
        check("r34_uerr", 32'(underflow_err), 1);
        tick();
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0);
        check("r34_uerr_fl", 32'(underflow_err), 1);
        tick();
        drive(1, 1, 8, 0, 0, 0, 8, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check("r34_rst_uerr", 32'(underflow_err), 0);
        check("r34_rst_tot",  32'(pending_total), 0);
        check("r34_rst_hz",   32'(hazard_detected), 0);
        check("r34_rst_rdy",  32'(issue_ready), 1);
        m_clear();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic on a small register window to hit saturation.
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                rst = 1'b0;
                #1;
                check("rand_rst_tot", 32'(pending_total), 0);
                m_clear();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                drive($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 5), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 5), $urandom_range(0, 29) == 0,
                      $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 1));
                tick();
            end
        end
        idle_tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 Parameter MAX_PEND, default 3, maximum in-flight writes tracked per architectural register (counter width 2 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserting (0) clears all state immediately.
REQ-004 issue_valid  input  1  an instruction leaves ID this cycle.
REQ-005 issue_wb_en  input  1  issuing instruction writes a register.
REQ-006 issue_dest  input  4  destination register of issuing instruction.
REQ-007 issue_ready  output  1  issue with write can be accepted (issue_dest counter below MAX_PEND).
REQ-008 wb_valid  input  1  WB stage retires a register write this cycle.
REQ-009 wb_dest  input  4  register written by WB.
REQ-010 flush  input  1  pipeline flush; discards all pending writes.
REQ-011 src_1, src_2  input  4 each  ID-stage source registers.
REQ-012 two_src  input  1  src_2 is a live operand.
REQ-013 hazard_detected  output  1  an ID source has a pending write.
REQ-014 pending_total  output  6  sum of all per-register counters.
REQ-015 underflow_err  output  1  sticky: WB retired a register with zero pending count.

Function
REQ-016 State: 16 counters pend[0..15], 2 bits each, plus underflow_err flop.
REQ-017 Issue accepted (inc) iff issue_valid & issue_wb_en & issue_ready; issue_valid with issue_wb_en=0 changes no state.
REQ-018 issue_ready = (pend[issue_dest] != MAX_PEND), combinational, independent of issue_valid.
REQ-019 Retire (dec) iff wb_valid & pend[wb_dest] != 0; wb_valid with pend[wb_dest]=0 leaves counters unchanged and sets underflow_err next edge.
REQ-020 Inc and dec on the same register in the same cycle: counter unchanged; on different registers: both applied.
REQ-021 Inc and underflowing wb on the same register (count 0): counter becomes 1, underflow_err not set (the inc covers the write).
REQ-022 flush=1: all counters cleared to 0 next edge, overriding any same-cycle inc/dec; underflow_err is not changed by flush.
REQ-023 hazard_detected = (pend[src_1] != 0) | (two_src & pend[src_2] != 0), computed combinationally from registered counters only; a same-cycle issue or retire does not affect it until the next cycle.
REQ-024 pending_total combinational sum of registered counters; range 0..48.
REQ-025 Counters never wrap: no increment above MAX_PEND, no decrement below 0.
REQ-026 Latency: counter change visible on hazard_detected, issue_ready and pending_total one cycle after the accepting edge.

Reset
REQ-027 rst=0 asynchronously forces all counters to 0 and underflow_err to 0, so hazard_detected=0, issue_ready=1, pending_total=0 without a clock edge.
REQ-028 rst deassertion mid-operation: first post-reset edge treats the inputs normally; no in-flight state is retained.

Verification
REQ-029 Issue dest=5 once; next cycle src_1=5 -> hazard_detected=1, pending_total=1; wb_dest=5 -> following cycle hazard_detected=0, pending_total=0.
REQ-030 src_2=7 pending with two_src=0 -> hazard_detected=0; two_src=1 -> hazard_detected=1.
REQ-031 Issue dest=3 three times -> issue_ready=0 with issue_dest=3; fourth issue_valid ignored, pending_total stays 3; one wb_dest=3 -> issue_ready=1.
REQ-032 pend[9]=1, same cycle issue dest=9 and wb dest=9 -> pend[9] stays 1, hazard on src_1=9 remains 1.
REQ-033 Pending on regs 1,2,4 plus flush with simultaneous issue dest=6 -> next cycle pending_total=0, no hazard for any source.
REQ-034 wb_dest=12 with nothing pending -> underflow_err=1 and stays 1 through flush; rst=0 mid-cycle -> underflow_err=0 and pending_total=0 immediately.
